keccak_state_mem: RTL

//  Responder side of the step-unit memory protocol (adr/in/r/w -> out) for the 5x5x64 Keccak state.

---
 rtl/keccak_state_mem_if.sv | 38 +++
 rtl/keccak_state_mem.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keccak_state_mem_if.sv
// Step-unit bus for the Keccak state memory: lane/slice access ports plus the
// controller's streaming load/unload channels.
interface keccak_state_mem_if;
    logic        mode;
    logic [4:0]  adr64;
    logic [63:0] in64;
    logic        r64;
    logic        w64;
    logic [63:0] out64;
    logic        vld64;
    logic [5:0]  adr25;
    logic [24:0] in25;
    logic        r25;
    logic        w25;
    logic [24:0] out25;
    logic        vld25;
    logic        ld_valid;
    logic [63:0] ld_data;
    logic        ld_ready;
    logic        ul_start;
    logic        ul_valid;
    logic [63:0] ul_data;
    logic        ul_ready;
    logic        ul_last;
    logic        busy;

    modport master (
        output mode, adr64, in64, r64, w64, adr25, in25, r25, w25,
               ld_valid, ld_data, ul_start, ul_ready,
        input  out64, vld64, out25, vld25, ld_ready, ul_valid, ul_data, ul_last, busy
    );

    modport slave (
        input  mode, adr64, in64, r64, w64, adr25, in25, r25, w25,
               ld_valid, ld_data, ul_start, ul_ready,
        output out64, vld64, out25, vld25, ld_ready, ul_valid, ul_data, ul_last, busy
    );
endinterface

// File: rtl/keccak_state_mem.sv
// 5x5x64 Keccak state store with lane/slice views and streaming load/unload.
// Optional sticky protocol-violation flag: define STATE_MEM_ERR_EN to add port err.
module keccak_state_mem #(
    parameter int LANE_W = 64,
    parameter int NLANES = 25
) (
    input  logic              clock,
    input  logic              reset,
    keccak_state_mem_if.slave bus
`ifdef STATE_MEM_ERR_EN
    ,
    output logic              err
`endif
);
    localparam logic [4:0] LAST_LANE = 5'(NLANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [4:0]          r_cnt;
    logic [4:0]          w_cnt_nxt;
    logic [LANE_W-1:0]   r_mem [NLANES];
    logic                w_ld_we;
    logic                w_ul_adv;
    logic                w_acc_en;
    logic                w_lane_sel;
    logic                w_slice_sel;
    logic                w_adr64_ok;
    logic                w_wr64;
    logic                w_rd64;
    logic                w_wr25;
    logic                w_rd25;
    logic [63:0]         w_rd64_data;
    logic [24:0]         w_slice;
    logic [63:0]         r_out64;
    logic                r_vld64;
    logic [24:0]         r_out25;
    logic                r_vld25;
    logic [63:0]         r_ul_data;
    logic                r_ul_valid;
    logic                r_ul_last;
    logic                r_busy;
    logic                r_ld_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; a load request in IDLE takes precedence over unload and access
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ld_we     = 1'b0;
        w_ul_adv    = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ld_valid) begin
                    w_ld_we     = 1'b1;
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = 5'd1;
                end else if (bus.ul_start) begin
                    w_state_nxt = ST_UNLOAD;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_acc_en    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    w_ld_we = 1'b1;
                    if (r_cnt == LAST_LANE) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 5'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_UNLOAD: begin
                if (r_ul_valid && bus.ul_ready) begin
                    w_ul_adv = 1'b1;
                    if (r_cnt == LAST_LANE) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 5'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    assign w_lane_sel  = w_acc_en & bus.mode;
    assign w_slice_sel = w_acc_en & ~bus.mode;
    assign w_adr64_ok  = (bus.adr64 <= LAST_LANE);
    assign w_wr64      = w_lane_sel & bus.w64 & w_adr64_ok;
    assign w_rd64      = w_lane_sel & bus.r64 & ~bus.w64;
    assign w_wr25      = w_slice_sel & bus.w25;
    assign w_rd25      = w_slice_sel & bus.r25 & ~bus.w25;

    // Read-data selection for both views; out-of-range lanes read as zero
    always_comb begin
        w_rd64_data = 64'd0;
        w_slice     = 25'd0;
        if (w_adr64_ok) begin
            w_rd64_data = r_mem[bus.adr64];
        end else begin
            w_rd64_data = 64'd0;
        end
        for (int i = 0; i < NLANES; i++) begin
            w_slice[i] = r_mem[i][bus.adr25];
        end
    end

    // Storage: streamed load, lane write, or slice write (bit z of every lane)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NLANES; i++) begin
                r_mem[i] <= {LANE_W{1'b0}};
            end
        end else if (w_ld_we) begin
            r_mem[r_cnt] <= bus.ld_data;
        end else if (w_wr64) begin
            r_mem[bus.adr64] <= bus.in64;
        end else if (w_wr25) begin
            for (int i = 0; i < NLANES; i++) begin
                r_mem[i][bus.adr25] <= bus.in25[i];
            end
        end
    end

    // Registered outputs; the unload word is fetched on entry and on every handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out64    <= 64'd0;
            r_vld64    <= 1'b0;
            r_out25    <= 25'd0;
            r_vld25    <= 1'b0;
            r_ul_data  <= 64'd0;
            r_ul_valid <= 1'b0;
            r_ul_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_ld_ready <= 1'b1;
        end else begin
            r_vld64 <= w_rd64;
            r_vld25 <= w_rd25;
            if (w_rd64) begin
                r_out64 <= w_rd64_data;
            end
            if (w_rd25) begin
                r_out25 <= w_slice;
            end
            if ((w_state_nxt == ST_UNLOAD) && ((r_state != ST_UNLOAD) || w_ul_adv)) begin
                r_ul_data <= r_mem[w_cnt_nxt];
            end
            r_ul_valid <= (w_state_nxt == ST_UNLOAD);
            r_ul_last  <= (w_state_nxt == ST_UNLOAD) && (w_cnt_nxt == LAST_LANE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_ld_ready <= (w_state_nxt != ST_UNLOAD);
        end
    end

    assign bus.out64    = r_out64;
    assign bus.vld64    = r_vld64;
    assign bus.out25    = r_out25;
    assign bus.vld25    = r_vld25;
    assign bus.ul_data  = r_ul_data;
    assign bus.ul_valid = r_ul_valid;
    assign bus.ul_last  = r_ul_last;
    assign bus.busy     = r_busy;
    assign bus.ld_ready = r_ld_ready;

`ifdef STATE_MEM_ERR_EN
    logic w_viol;
    logic r_err;

    assign w_viol = (bus.r64 & bus.w64)
                  | (bus.r25 & bus.w25)
                  | (bus.mode ? (bus.r25 | bus.w25) : (bus.r64 | bus.w64))
                  | ((r_state != ST_IDLE) & (bus.r64 | bus.w64 | bus.r25 | bus.w25))
                  | (bus.mode & (bus.r64 | bus.w64) & ~w_adr64_ok)
                  | ((r_state != ST_IDLE) & bus.ul_start);

    // Sticky violation flag, cleared only by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_viol) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif
endmodule
